// File: rtl/fifo8_rr_sched_if.sv
`default_nettype none
// =============================================================================
// Module   : fifo8_rr_sched_if
// Brief    : Requester and FIFO-side bundle for the fifo8_rr_sched scheduler.
// Revision : 1.0 - initial release
// =============================================================================
interface fifo8_rr_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  w0_req;
    logic [DATA_WIDTH-1:0] w0_data;
    logic                  w0_done;
    logic                  w0_err;

    logic                  w1_req;
    logic [DATA_WIDTH-1:0] w1_data;
    logic                  w1_done;
    logic                  w1_err;

    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_done;
    logic                  r_err;

    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_wr_ack;
    logic                  fifo_wr_err;
    logic                  fifo_rd_ack;
    logic                  fifo_rd_err;

    logic                  busy;
    logic                  to_flag;

    // Scheduler side
    modport slave (
        input  w0_req, w0_data, w1_req, w1_data, r_req,
        input  fifo_dout, fifo_wr_ack, fifo_wr_err, fifo_rd_ack, fifo_rd_err,
        output w0_done, w0_err, w1_done, w1_err, r_data, r_done, r_err,
        output fifo_wr_en, fifo_rd_en, fifo_din, busy, to_flag
    );

    // Requesters plus FIFO side
    modport master (
        output w0_req, w0_data, w1_req, w1_data, r_req,
        output fifo_dout, fifo_wr_ack, fifo_wr_err, fifo_rd_ack, fifo_rd_err,
        input  w0_done, w0_err, w1_done, w1_err, r_data, r_done, r_err,
        input  fifo_wr_en, fifo_rd_en, fifo_din, busy, to_flag
    );
endinterface
`default_nettype wire

// File: rtl/fifo8_rr_sched.sv
`default_nettype none
// =============================================================================
// Module   : fifo8_rr_sched
// Brief    : Round-robin scheduler sharing one FIFO between W0, W1 and R.
// Revision : 1.0 - initial release
// =============================================================================
module fifo8_rr_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 3
) (
    input wire              clk,
    input wire              reset_n,
    fifo8_rr_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_id_w0       = 2'd0;
    localparam logic [1:0] c_id_w1       = 2'd1;
    localparam logic [1:0] c_id_r        = 2'd2;
    localparam logic [3:0] c_wait_last   = 4'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_id;
    logic [1:0]            w_id_nxt;
    logic [1:0]            r_ptr;
    logic [1:0]            w_ptr_nxt;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] w_word_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_ok;
    logic                  w_ok_nxt;
    logic                  r_to;
    logic                  w_to_nxt;

    logic                  w_any_req;
    logic [1:0]            w_pick;
    logic                  w_is_write;
    logic                  w_rsp_ack;
    logic                  w_rsp_err;
    logic                  w_in_resp;
    logic                  w_in_issue;

    assign w_any_req = bus.w0_req | bus.w1_req | bus.r_req;

    // First active requester in W0 -> W1 -> R order, starting at the pointer.
    always_comb begin
        w_pick = c_id_w0;
        case (r_ptr)
            c_id_w1: w_pick = bus.w1_req ? c_id_w1 : (bus.r_req  ? c_id_r  : c_id_w0);
            c_id_r:  w_pick = bus.r_req  ? c_id_r  : (bus.w0_req ? c_id_w0 : c_id_w1);
            default: w_pick = bus.w0_req ? c_id_w0 : (bus.w1_req ? c_id_w1 : c_id_r);
        endcase
    end

    assign w_is_write = (r_id != c_id_r);
    assign w_rsp_ack  = w_is_write ? bus.fifo_wr_ack : bus.fifo_rd_ack;
    assign w_rsp_err  = w_is_write ? bus.fifo_wr_err : bus.fifo_rd_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_id    <= c_id_w0;
            r_ptr   <= c_id_w0;
            r_word  <= '0;
            r_rdata <= '0;
            r_cnt   <= 4'd0;
            r_ok    <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            r_ptr   <= w_ptr_nxt;
            r_word  <= w_word_nxt;
            r_rdata <= w_rdata_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ok    <= w_ok_nxt;
            r_to    <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_ptr_nxt   = r_ptr;
        w_word_nxt  = r_word;
        w_rdata_nxt = r_rdata;
        w_cnt_nxt   = r_cnt;
        w_ok_nxt    = r_ok;
        w_to_nxt    = r_to;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                    w_id_nxt    = w_pick;
                    w_ptr_nxt   = (w_pick == c_id_r) ? c_id_w0 : (w_pick + 2'd1);
                    if (w_pick == c_id_w0) begin
                        w_word_nxt = bus.w0_data;
                    end else if (w_pick == c_id_w1) begin
                        w_word_nxt = bus.w1_data;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = 4'd0;
            end
            S_WAIT: begin
                // Error beats ack when the FIFO reports both.
                if (w_rsp_err) begin
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = S_RESP;
                end else if (w_rsp_ack) begin
                    w_ok_nxt    = 1'b1;
                    w_state_nxt = S_RESP;
                    if (!w_is_write) begin
                        w_rdata_nxt = bus.fifo_dout;
                    end
                end else if (r_cnt == c_wait_last) begin
                    w_ok_nxt    = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state.
    assign w_in_resp  = (r_state == S_RESP);
    assign w_in_issue = (r_state == S_ISSUE);

    assign bus.w0_done    = w_in_resp && (r_id == c_id_w0) &&  r_ok;
    assign bus.w0_err     = w_in_resp && (r_id == c_id_w0) && !r_ok;
    assign bus.w1_done    = w_in_resp && (r_id == c_id_w1) &&  r_ok;
    assign bus.w1_err     = w_in_resp && (r_id == c_id_w1) && !r_ok;
    assign bus.r_done     = w_in_resp && (r_id == c_id_r)  &&  r_ok;
    assign bus.r_err      = w_in_resp && (r_id == c_id_r)  && !r_ok;
    assign bus.r_data     = bus.r_done ? r_rdata : '0;

    assign bus.fifo_wr_en = w_in_issue &&  w_is_write;
    assign bus.fifo_rd_en = w_in_issue && !w_is_write;
    assign bus.fifo_din   = bus.fifo_wr_en ? r_word : '0;

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.to_flag    = r_to;

endmodule
`default_nettype wire

// File: tb/tb_fifo8_rr_sched.sv
`default_nettype none
// =============================================================================
// Module   : tb_fifo8_rr_sched
// Brief    : Randomized bench for fifo8_rr_sched with an 8-deep FIFO responder.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fifo8_rr_sched;

    localparam int DW  = 32;
    localparam int TMO = 3;

    logic clk;
    logic reset_n;
    bit   fifo_mute;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo8_rr_sched_if #(.DATA_WIDTH(DW)) bus ();

    fifo8_rr_sched #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // FIFO responder: answers one cycle after an enable, silent while muted.
    logic [DW-1:0] f_mem [8];
    int f_cnt, f_rp, f_wp;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_cnt <= 0; f_rp <= 0; f_wp <= 0;
            bus.fifo_wr_ack <= 1'b0; bus.fifo_wr_err <= 1'b0;
            bus.fifo_rd_ack <= 1'b0; bus.fifo_rd_err <= 1'b0;
            bus.fifo_dout   <= '0;
        end else begin
            bus.fifo_wr_ack <= 1'b0; bus.fifo_wr_err <= 1'b0;
            bus.fifo_rd_ack <= 1'b0; bus.fifo_rd_err <= 1'b0;
            if (!fifo_mute && bus.fifo_wr_en && !bus.fifo_rd_en) begin
                if (f_cnt < 8) begin
                    f_mem[f_wp] <= bus.fifo_din;
                    f_wp  <= (f_wp + 1) % 8;
                    f_cnt <= f_cnt + 1;
                    bus.fifo_wr_ack <= 1'b1;
                end else begin
                    bus.fifo_wr_err <= 1'b1;
                end
            end else if (!fifo_mute && bus.fifo_rd_en && !bus.fifo_wr_en) begin
                if (f_cnt > 0) begin
                    bus.fifo_dout <= f_mem[f_rp];
                    f_rp  <= (f_rp + 1) % 8;
                    f_cnt <= f_cnt - 1;
                    bus.fifo_rd_ack <= 1'b1;
                end else begin
                    bus.fifo_rd_err <= 1'b1;
                end
            end
        end
    end

    int n_total, n_bad, cyc;

    // Requester agents: index 0 = W0, 1 = W1, 2 = R.
    bit            a_pend  [3];
    bit            a_raise [3];
    logic [DW-1:0] a_data  [3];
    logic [DW-1:0] a_rdat  [3];
    bit            rand_on;

    // Reference: one operation at a time, timed from the cycle it is picked.
    int            m_ptr, m_s, m_resp, m_free, m_id;
    logic [DW-1:0] m_data, m_rdata;
    bit            m_ok, m_tmo, m_to;
    logic [DW-1:0] g_q [$];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        bus.w0_req  = a_pend[0];
        bus.w0_data = a_pend[0] ? a_data[0] : '0;
        bus.w1_req  = a_pend[1];
        bus.w1_data = a_pend[1] ? a_data[1] : '0;
        bus.r_req   = a_pend[2];
    endtask

    task automatic tick();
        bit            e_busy, e_wr, e_rd, found;
        logic [DW-1:0] e_din, e_rdat;
        bit            e_done [3];
        bit            e_err  [3];
        bit            g_done [3];
        bit            g_err  [3];
        @(negedge clk);
        cyc++;
        e_busy = (cyc > m_s) && (cyc <= m_resp);
        e_wr   = (cyc == m_s + 1) && (m_id != 2);
        e_rd   = (cyc == m_s + 1) && (m_id == 2);
        e_din  = e_wr ? m_data : '0;
        e_rdat = '0;
        for (int i = 0; i < 3; i++) begin
            e_done[i] = 1'b0;
            e_err[i]  = 1'b0;
        end
        if (cyc == m_resp) begin
            e_done[m_id] = m_ok;
            e_err[m_id]  = !m_ok;
            if (m_ok && m_id == 2) e_rdat = m_rdata;
            if (m_tmo) m_to = 1'b1;
        end
        g_done[0] = bus.w0_done; g_done[1] = bus.w1_done; g_done[2] = bus.r_done;
        g_err[0]  = bus.w0_err;  g_err[1]  = bus.w1_err;  g_err[2]  = bus.r_err;

        check_eq("busy",    DW'(bus.busy),       DW'(e_busy));
        check_eq("wr_en",   DW'(bus.fifo_wr_en), DW'(e_wr));
        check_eq("rd_en",   DW'(bus.fifo_rd_en), DW'(e_rd));
        check_eq("excl",    DW'(bus.fifo_wr_en & bus.fifo_rd_en), '0);
        check_eq("din",     bus.fifo_din, e_din);
        check_eq("r_data",  bus.r_data,   e_rdat);
        check_eq("to_flag", DW'(bus.to_flag), DW'(m_to));
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("done%0d", i), DW'(g_done[i]), DW'(e_done[i]));
            check_eq($sformatf("err%0d", i),  DW'(g_err[i]),  DW'(e_err[i]));
        end

        for (int i = 0; i < 3; i++) begin
            if (a_pend[i] && (g_done[i] || g_err[i])) begin
                a_pend[i] = 1'b0;
            end else if (!a_pend[i] && (a_raise[i] || (rand_on && $urandom_range(2) == 0))) begin
                a_pend[i] = 1'b1;
                a_data[i] = a_raise[i] ? a_rdat[i] : DW'($urandom());
            end
            a_raise[i] = 1'b0;
        end
        drive();

        if (cyc >= m_free && (a_pend[0] || a_pend[1] || a_pend[2])) begin
            found = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!found && a_pend[(m_ptr + k) % 3]) begin
                    found = 1'b1;
                    m_id  = (m_ptr + k) % 3;
                end
            end
            m_ptr  = (m_id + 1) % 3;
            m_s    = cyc;
            m_data = a_data[m_id];
            m_tmo  = fifo_mute;
            m_resp = cyc + (fifo_mute ? 2 + TMO : 3);
            m_free = m_resp + 1;
            if (fifo_mute) begin
                m_ok = 1'b0;
            end else if (m_id != 2) begin
                m_ok = (g_q.size() < 8);
                if (m_ok) g_q.push_back(m_data);
            end else begin
                m_ok = (g_q.size() > 0);
                if (m_ok) m_rdata = g_q.pop_front();
            end
        end
    endtask

    task automatic do_ops(input bit [2:0] mask, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        for (int i = 0; i < 3; i++) a_raise[i] = mask[i];
        a_rdat[0] = d0;
        a_rdat[1] = d1;
        a_rdat[2] = '0;
        tick();
        for (int k = 0; k < 40 && (a_pend[0] || a_pend[1] || a_pend[2]); k++) tick();
        check_eq("drain", DW'({a_pend[0], a_pend[1], a_pend[2]}), '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_flags", DW'({bus.w0_done, bus.w0_err, bus.w1_done, bus.w1_err,
                                   bus.r_done, bus.r_err, bus.fifo_wr_en, bus.fifo_rd_en,
                                   bus.busy, bus.to_flag}), '0);
        check_eq("rst_din",   bus.fifo_din, '0);
        check_eq("rst_rdata", bus.r_data,   '0);
        for (int i = 0; i < 3; i++) begin
            a_pend[i]  = 1'b0;
            a_raise[i] = 1'b0;
        end
        drive();
        m_s = -100; m_resp = -100; m_free = 0; m_ptr = 0; m_id = 0;
        m_to = 1'b0; m_tmo = 1'b0;
        g_q.delete();
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0;
        rand_on = 1'b0; fifo_mute = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_pend[i] = 1'b0; a_raise[i] = 1'b0; a_data[i] = '0; a_rdat[i] = '0;
        end
        drive();
        #2;
        do_reset();

        // Empty read, then a lone write
        do_ops(3'b100, '0, '0);
        do_ops(3'b001, 32'hDEAD_BEEF, '0);

        // All three at reset exit: order W0, W1, R
        do_reset();
        do_ops(3'b111, 32'h1111_0001, 32'h2222_0002);

        // Fill past capacity, then drain past empty
        do_reset();
        for (int v = 1; v <= 9; v++) do_ops(3'b001, DW'(v), '0);
        for (int v = 1; v <= 9; v++) do_ops(3'b100, '0, '0);

        // Silent FIFO: W1 times out and the sticky flag stays up
        fifo_mute = 1'b1;
        do_ops(3'b010, '0, 32'h0BAD_0001);
        fifo_mute = 1'b0;
        repeat (3) tick();
        do_ops(3'b001, 32'h5555_AAAA, '0);

        // Reset during WAIT of a W0 write
        a_raise[0] = 1'b1;
        a_rdat[0]  = 32'hCAFE_0001;
        tick(); tick(); tick();
        do_reset();
        repeat (4) tick();
        do_ops(3'b101, 32'h0000_0A0A, '0);
        do_ops(3'b010, '0, 32'h0000_0B0B);

        // Random traffic
        rand_on = 1'b1;
        repeat (600) tick();
        rand_on = 1'b0;
        for (int k = 0; k < 40 && (a_pend[0] || a_pend[1] || a_pend[2]); k++) tick();
        check_eq("final_drain", DW'({a_pend[0], a_pend[1], a_pend[2]}), '0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
